// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StAck,
        StErr
    } state_e;

    localparam logic [7:0] ACK_DEFAULT = 8'hAA;
    localparam logic [7:0] NAK_DEFAULT = 8'hEE;
    localparam int unsigned IDX_W = 2;

endpackage

// File: rtl/byte_packer.sv
// Assembles four bytes into a little-endian 32-bit word; the completed word is
// presented combinationally alongside the strobe carrying its last byte.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [IDX_W-1:0] idx_q;
    logic [31:0]      word_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (in_valid) begin
            word_q[{idx_q, 3'b000} +: 8] <= in_byte;
            idx_q                        <= idx_q + IDX_W'(1);
        end
    end

    assign word_valid = in_valid && (idx_q == '1);
    assign word       = {in_byte, word_q[23:0]};

endmodule

// File: rtl/uart_program_loader.sv
// Boot-time loader: streams a length-prefixed image from the UART into
// instruction memory and reports ACK/NAK back through the UART.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W   = 14,
    parameter logic [7:0]  ACK_BYTE = ACK_DEFAULT,
    parameter logic [7:0]  NAK_BYTE = NAK_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_ready,
    input  logic [7:0]        r_data,
    input  logic              tx_ready,
    output logic [7:0]        t_data,
    output logic              t_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   cnt_q;
    logic              nak_sent_q;
    logic              done_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic        start_ok;
    logic        pk_valid;
    logic        pk_word_valid;
    logic [31:0] pk_word;
    logic        len_too_big;
    logic        last_word;
    logic        tx_fire;

    assign start_ok = start && (state_q == StIdle || state_q == StErr);
    assign pk_valid = rx_ready && (state_q == StLen || state_q == StData);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .in_valid   (pk_valid),
        .in_byte    (r_data),
        .word_valid (pk_word_valid),
        .word       (pk_word)
    );

    // A full capacity image (N == 2^ADDR_W) is legal, hence the 33-bit compare.
    assign len_too_big = {1'b0, pk_word} > (33'd1 << ADDR_W);
    assign last_word   = (cnt_q == len_q - (ADDR_W + 1)'(1));
    assign tx_fire     = tx_ready && (state_q == StAck || (state_q == StErr && !nak_sent_q));

    always_comb begin
        state_d = state_q;
        t_valid = tx_fire;
        t_data  = 8'h00;
        busy    = (state_q == StLen) || (state_q == StData) || (state_q == StAck);
        err     = (state_q == StErr);
        if (tx_fire) begin
            t_data = (state_q == StAck) ? ACK_BYTE : NAK_BYTE;
        end
        unique case (state_q)
            StIdle: if (start_ok) state_d = StLen;
            StLen: begin
                if (pk_word_valid) begin
                    if (pk_word == 32'd0)  state_d = StAck;
                    else if (len_too_big)  state_d = StErr;
                    else                   state_d = StData;
                end
            end
            StData: if (pk_word_valid && last_word) state_d = StAck;
            StAck:  if (tx_ready) state_d = StIdle;
            StErr:  if (start_ok) state_d = StLen;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= '0;
            cnt_q       <= '0;
            nak_sent_q  <= 1'b0;
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            done_q   <= (state_q == StAck) && tx_ready;
            mem_we_q <= 1'b0;
            if (start_ok) begin
                cnt_q      <= '0;
                nak_sent_q <= 1'b0;
            end
            if (state_q == StLen && pk_word_valid) begin
                len_q <= pk_word[ADDR_W:0];
            end
            if (state_q == StData && pk_word_valid) begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= cnt_q[ADDR_W-1:0];
                mem_wdata_q <= pk_word;
                cnt_q       <= cnt_q + (ADDR_W + 1)'(1);
            end
            if (state_q == StErr && tx_fire) begin
                nak_sent_q <= 1'b1;
            end
        end
    end

    assign done      = done_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomised self-checking bench for uart_program_loader (ADDR_W = 4).
module tb_uart_program_loader;

    localparam int unsigned AW  = 4;
    localparam int          CAP = 16;

    logic          clk = 1'b0;
    logic          rst, start, rx_ready, tx_ready;
    logic [7:0]    r_data, t_data;
    logic          t_valid, mem_we, busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    uart_program_loader #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rx_ready  (rx_ready),
        .r_data    (r_data),
        .tx_ready  (tx_ready),
        .t_data    (t_data),
        .t_valid   (t_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation log, filled at the falling edge.
    int          wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    logic [7:0]  txb[$];
    int          txc[$];
    int          dc[$];
    int          tv_bad = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(int'(mem_addr));
            wd.push_back(mem_wdata);
            wc.push_back(cyc);
        end
        if (t_valid) begin
            txb.push_back(t_data);
            txc.push_back(cyc);
            if (!tx_ready) tv_bad++;
        end
        if (done) dc.push_back(cyc);
    end

    // Reference image for the current scenario.
    int          en;
    logic [31:0] ew[$];

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete();
        txb.delete(); txc.delete(); dc.delete();
        tv_bad = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_ready = 1'b1;
        r_data   = b;
        last_cyc = cyc;
        idle(1);
        rx_ready = 1'b0;
    endtask

    task automatic send_word32(input logic [31:0] w);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        idle(1);
        start = 1'b0;
    endtask

    task automatic make_image(input int n);
        en = n;
        ew.delete();
        for (int i = 0; i < n; i++) ew.push_back($urandom);
    endtask

    task automatic run_load(input int gapmax);
        pulse_start();
        send_word32(32'(en));
        for (int i = 0; i < en; i++) begin
            for (int b = 0; b < 4; b++) begin
                idle($urandom_range(0, gapmax));
                send_byte(ew[i][8*b +: 8]);
            end
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n0 = dc.size();
        for (int i = 0; i < budget && dc.size() == n0; i++) idle(1);
        total++;
        if (dc.size() == n0) begin
            bad++;
            $display("FAIL %s done_timeout got none want pulse within %0d cycles", name, budget);
        end
    endtask

    // Compare the log against what the image rules say must happen.
    task automatic check_load(input string name);
        int         exp_n  = (en <= CAP) ? en : 0;
        logic [7:0] exp_tx = (en <= CAP) ? 8'hAA : 8'hEE;
        int         exp_d  = (en <= CAP) ? 1 : 0;
        total++;
        if (wa.size() != exp_n) begin
            bad++;
            $display("FAIL %s write_count got %0d want %0d", name, wa.size(), exp_n);
        end
        for (int i = 0; i < wa.size() && i < exp_n; i++) begin
            total++;
            if (wa[i] != i || wd[i] !== ew[i]) begin
                bad++;
                $display("FAIL %s write%0d got (%0d,%h) want (%0d,%h)", name, i, wa[i], wd[i],
                         i, ew[i]);
            end
        end
        total++;
        if (txb.size() != 1 || txb[0] !== exp_tx) begin
            bad++;
            $display("FAIL %s tx got %0d bytes first=%h want 1 byte %h", name, txb.size(),
                     (txb.size() > 0) ? txb[0] : 8'h00, exp_tx);
        end
        total++;
        if (dc.size() != exp_d || tv_bad != 0) begin
            bad++;
            $display("FAIL %s done/tv got done=%0d tv_bad=%0d want done=%0d tv_bad=0", name,
                     dc.size(), tv_bad, exp_d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        total++;
        if ({t_data, t_valid, mem_we, mem_addr, mem_wdata, busy, done, err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got %h want 0",
                     {t_data, t_valid, mem_we, mem_addr, mem_wdata, busy, done, err});
        end
        rst = 1'b0;
        idle(1);
        total++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got busy=%b err=%b want 0 0", busy, err);
        end
    endtask

    task automatic test_normal();
        clear_log();
        en = 2;
        ew.delete();
        ew.push_back(32'h12345678);
        ew.push_back(32'hDEADBEEF);
        run_load(0);
        wait_done("normal", 20);
        check_load("normal");
        total++;
        if (wc.size() != 2 || wc[1] != last_cyc + 1) begin
            bad++;
            $display("FAIL normal_write_latency got cyc %0d want %0d",
                     (wc.size() == 2) ? wc[1] : -1, last_cyc + 1);
        end
        total++;
        if (txc.size() != 1 || dc.size() != 1 || dc[0] != txc[0] + 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL normal_done_timing got done_cyc=%0d busy=%b want tx_cyc+1 busy=0",
                     (dc.size() > 0) ? dc[0] : -1, busy);
        end
    endtask

    task automatic test_empty();
        clear_log();
        make_image(0);
        run_load(0);
        wait_done("empty", 20);
        check_load("empty");
    endtask

    task automatic test_overlength();
        clear_log();
        make_image(17);
        pulse_start();
        send_word32(32'd17);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom));
        idle(15);
        check_load("overlength");
        total++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL overlength_err got err=%b busy=%b want 1 0", err, busy);
        end
        pulse_start();
        total++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL overlength_restart got err=%b busy=%b want 0 1", err, busy);
        end
        clear_log();
        make_image(1);
        send_word32(32'd1);
        send_word32(ew[0]);
        wait_done("after_err", 20);
        check_load("after_err");
    endtask

    task automatic test_boundary();
        clear_log();
        make_image(CAP);
        run_load(1);
        wait_done("boundary", 20);
        check_load("boundary");
        total++;
        if (wa.size() == 0 || wa[wa.size()-1] != CAP - 1) begin
            bad++;
            $display("FAIL boundary_last_addr got %0d want %0d",
                     (wa.size() > 0) ? wa[wa.size()-1] : -1, CAP - 1);
        end
    endtask

    task automatic test_backpressure();
        int c;
        clear_log();
        tx_ready = 1'b0;
        make_image(1);
        run_load(0);
        idle(20);
        total++;
        if (txb.size() != 0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_hold got tx=%0d busy=%b want 0 1", txb.size(), busy);
        end
        tx_ready = 1'b1;
        c = cyc;
        idle(1);
        total++;
        if (txc.size() != 1 || txc[0] != c) begin
            bad++;
            $display("FAIL backpressure_release got tx_cyc=%0d want %0d",
                     (txc.size() > 0) ? txc[0] : -1, c);
        end
        wait_done("backpressure", 10);
        check_load("backpressure");
    endtask

    task automatic test_reset_mid();
        clear_log();
        pulse_start();
        send_word32(32'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        total++;
        if ({t_data, t_valid, mem_we, mem_addr, mem_wdata, busy, done, err} !== '0 ||
            wa.size() != 0) begin
            bad++;
            $display("FAIL reset_mid_outputs got %h writes=%0d want 0 0",
                     {t_data, t_valid, mem_we, mem_addr, mem_wdata, busy, done, err}, wa.size());
        end
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        idle(3);
        total++;
        if (wa.size() != 0 || busy !== 1'b0 || txb.size() != 0) begin
            bad++;
            $display("FAIL reset_mid_idle got writes=%0d busy=%b tx=%0d want 0 0 0",
                     wa.size(), busy, txb.size());
        end
        make_image(3);
        run_load(0);
        wait_done("reset_mid_reload", 20);
        check_load("reset_mid_reload");
    endtask

    task automatic test_start_with_rx();
        clear_log();
        make_image(1);
        start    = 1'b1;
        rx_ready = 1'b1;
        r_data   = 8'h05;
        idle(1);
        start    = 1'b0;
        rx_ready = 1'b0;
        send_word32(32'd1);
        send_word32(ew[0]);
        wait_done("start_with_rx", 20);
        check_load("start_with_rx");
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 6; it++) begin
            clear_log();
            make_image($urandom_range(0, CAP));
            run_load((it % 2 == 0) ? 0 : 2);
            wait_done("random", 20);
            check_load("random");
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_ready = 1'b0;
        r_data   = 8'h00;
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_normal();
        test_empty();
        test_overlength();
        test_boundary();
        test_backpressure();
        test_reset_mid();
        test_start_with_rx();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before 50000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
